// File: rtl/sram_controller_if.sv
// MEM-stage request/response bus for the external-SRAM data memory.
// The MEM stage is the master; sram_controller is the slave.
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;

  modport master (output rd_en, wr_en, address, writeData, input readData, ready);
  modport slave  (input rd_en, wr_en, address, writeData, output readData, ready);
endinterface

// File: rtl/sram_controller.sv
// 32-bit MEM-stage access split into two 16-bit async SRAM half-word phases.
// ready drops for the whole access so the pipeline freezes until DONE.
module sram_controller #(
  parameter int HALF_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_controller_if.slave      bus,
  inout  wire   [15:0]          SRAM_DQ,
  output logic  [17:0]          SRAM_ADDR,
  output logic                  SRAM_WE_N,
  output logic                  SRAM_OE_N,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_UB_N,
  output logic                  SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(HALF_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        is_wr, is_wr_nxt;
  logic        cap_lo, cap_hi;
  logic        active, half, ready;
  logic [31:0] rdata;
  logic [15:0] dq_out;
  logic        dq_oe;

  // Only the word index reaches the SRAM; byte offset and upper bits alias.
  wire unused_addr = &{1'b0, bus.address[31:19], bus.address[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      is_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      is_wr <= is_wr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    is_wr_nxt = is_wr;
    cap_lo    = 1'b0;
    cap_hi    = 1'b0;
    active    = 1'b0;
    half      = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = !(bus.rd_en | bus.wr_en);
        if (bus.wr_en | bus.rd_en) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
          is_wr_nxt = bus.wr_en;
        end
      end
      LOW: begin
        active = 1'b1;
        if (cnt == LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          cap_lo    = !is_wr;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HIGH: begin
        active = 1'b1;
        half   = 1'b1;
        if (cnt == LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          cap_hi    = !is_wr;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: begin
        half      = 1'b1;
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read halves land on the edge that closes each phase; writes leave rdata alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      if (cap_lo) rdata[15:0]  <= SRAM_DQ;
      if (cap_hi) rdata[31:16] <= SRAM_DQ;
    end
  end

  assign bus.readData = rdata;
  assign bus.ready    = ready;

  assign SRAM_ADDR = (state == IDLE) ? 18'd0 : {bus.address[18:2], half};
  assign SRAM_WE_N = !(active &&  is_wr);
  assign SRAM_OE_N = !(active && !is_wr);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign dq_oe   = active && is_wr;
  assign dq_out  = half ? bus.writeData[31:16] : bus.writeData[15:0];
  assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle data-memory controller that replaces the MEM stage's internal register-array store with an external 16-bit asynchronous SRAM (256K x 16). It accepts the MEM stage's 32-bit read/write requests and splits each one into two 16-bit half-word accesses. It holds `ready` low while an access is in flight so the pipeline freezes. The MEM stage drives this block, and the MEM/WB register consumes `readData` in the cycle `ready` returns high.

## Interface
Parameters:
- `HALF_CYCLES`, default 3: clock cycles spent on each 16-bit half-word access. Legal range is 1..15.

Ports:
- `clk`  in  1  the single system clock, rising edge.
- `rst`  in  1  reset. Asynchronous and active-high.
- `rd_en`  in  1  read request from the MEM stage. Held until `ready`=1.
- `wr_en`  in  1  write request from the MEM stage. Held until `ready`=1. Takes priority over `rd_en` when both are high.
- `address`  in  32  byte address. The word index is `address[18:2]`. All other bits are ignored.
- `writeData`  in  32  write data. Must be stable while the request is held.
- `readData`  out  32  registered read result. Valid in the cycle `ready`=1 that ends a read.
- `ready`  out  1  combinational. 0 means the pipeline must freeze.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address, equal to {`address[18:2]`, `half`}.
- `SRAM_WE_N`, `SRAM_OE_N`  out  1  active-low write enable and output enable.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N`  out  1  tied to 0.

## Operation
- FSM states are IDLE, LOW, HIGH and DONE. A 4-bit `cnt` counts the cycles spent in the current phase.
- IDLE:
  - If `wr_en` or `rd_en` is high, the next state is LOW with `cnt`=0.
  - The operation type (write if `wr_en`, else read) is latched at this edge.
- LOW:
  - `half`=0, so the access covers bits [15:0].
  - `cnt` increments each cycle.
  - When `cnt`==HALF_CYCLES-1, the next state is HIGH, `cnt` clears, and on a read `SRAM_DQ` is captured into `readData[15:0]`.
- HIGH:
  - `half`=1, so the access covers bits [31:16].
  - The same counting rule applies.
  - At the end of the phase the next state is DONE, and on a read `SRAM_DQ` is captured into `readData[31:16]`.
- DONE: the next state is always IDLE. The block does not start a back-to-back request directly from DONE.
- `ready` =
  - 1 in DONE;
  - !(`rd_en`|`wr_en`) in IDLE;
  - 0 in LOW and HIGH.
- Write phases:
  - `SRAM_WE_N`=0 and `SRAM_OE_N`=1.
  - `SRAM_DQ` is driven with `writeData[15:0]` in LOW and `writeData[31:16]` in HIGH.
- Read phases:
  - `SRAM_WE_N`=1, `SRAM_OE_N`=0, and `SRAM_DQ` is high-Z.
- IDLE and DONE: `SRAM_WE_N`=1, `SRAM_OE_N`=1, and `SRAM_DQ` is high-Z.
- `SRAM_ADDR` is 0 in IDLE.
- `readData` changes only on the two read capture edges. It keeps its value across writes and idle cycles.
- Ordering is little-endian: the even half-word (`half`=0) holds the low 16 bits.

## Timing
- Reset values: state IDLE, `cnt`=0, `readData`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ` high-Z, `SRAM_ADDR`=0.
  - `ready` follows the IDLE rule.
- Access timing, where a request is first seen in IDLE at cycle 0:
  - LOW occupies cycles 1..HALF_CYCLES.
  - HIGH occupies cycles HALF_CYCLES+1..2·HALF_CYCLES.
  - DONE is cycle 2·HALF_CYCLES+1.
  - `ready`=0 for 2·HALF_CYCLES+1 cycles. With the default this is 7 cycles, and `ready`=1 in cycle 7.
- The pipeline advances on the rising edge that ends the DONE cycle.
- A request that is still present in the following IDLE cycle is treated as a new access. Requesters must therefore drop or change the request at that edge, which the frozen pipeline does naturally.
- Changing `rd_en`, `wr_en`, `address` or `writeData` mid-access is illegal. The block is not required to detect it.
- If `rst` rises mid-operation, the FSM aborts immediately and asynchronously to the reset values.
  - A partially written word is left with only its low half updated. This is acceptable.
- With HALF_CYCLES=1, each phase lasts exactly one cycle and the total stall is 3 cycles.

## Test plan
- Reset idle: assert `rst` with no requests, then release it.
  - Required: `ready`=1, `readData`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z.
- Write then read back:
  - Write 0xDEADBEEF to address 0x0000_0010. Required: `SRAM_ADDR`=8 with DQ=0xBEEF, then `SRAM_ADDR`=9 with DQ=0xDEAD, and `ready`=1 in cycle 7.
  - Then read 0x10. Required: `readData`=0xDEADBEEF in its DONE cycle.
- Back-to-back requests: a write to 0x4 followed by a read from 0x4, each held until `ready`.
  - Required: two separate 7-cycle stalls, one IDLE cycle between them, and a correct readback.
- Simultaneous `rd_en`=`wr_en`=1 at 0x8 with data 0x12345678.
  - Required: a write is performed, a later read returns 0x12345678, and `readData` is unchanged during the write.
- Address aliasing: write 0xCAFEF00D to 0x8000_0020.
  - Required: a read of 0x0000_0020 returns 0xCAFEF00D, because bits above 18 are ignored.
- Reset during the HIGH phase of a write of 0xAAAA5555 to 0x0.
  - Required: outputs return to their reset values immediately, and a later read of 0x0 shows a low half of 0x5555.
